// File: rtl/ffn_silu_ctrl_if.sv
// Handshake and lane-vector bundle between the hard-SiLU controller and its
// host (start/gate input, shared FMA array operands/result, SiLU result).
interface ffn_silu_ctrl_if #(
  parameter int BW_FP    = 17,
  parameter int VALUE_MK = 128
);
  logic                      start_silu;
  logic [VALUE_MK*BW_FP-1:0] gate_proj;
  logic [VALUE_MK*BW_FP-1:0] FMA_out;
  logic                      busy_silu;
  logic [VALUE_MK*5-1:0]     mode_silu;
  logic [VALUE_MK*BW_FP-1:0] a_silu;
  logic [VALUE_MK*BW_FP-1:0] b_silu;
  logic [VALUE_MK*BW_FP-1:0] c_silu;
  logic [VALUE_MK*BW_FP-1:0] silu_out;
  logic                      start_ffn_mul;

  modport master (
    output start_silu, gate_proj, FMA_out,
    input  busy_silu, mode_silu, a_silu, b_silu, c_silu, silu_out, start_ffn_mul
  );

  modport slave (
    input  start_silu, gate_proj, FMA_out,
    output busy_silu, mode_silu, a_silu, b_silu, c_silu, silu_out, start_ffn_mul
  );
endinterface

// File: rtl/ffn_silu_ctrl.sv
// Hard-SiLU sequencer: y = x * clamp(0.25*x + 0.5, 0, 1) per lane, borrowing
// the shared FMA array (2-cycle latency) for one FMA pass and one MUL pass.
//
// state         | meaning
// K0_ISSUE_FMA  | FMA operands on the array: x*0.25 + 0.5
// K1_WAIT       | FMA in flight
// K2_CAP_T      | clamp FMA_out into t, launch MUL operands x*t
// K3_ISSUE_MUL  | MUL operands on the array
// K4_WAIT       | MUL in flight
// K5_CAP_Y      | capture FMA_out into silu_out, go idle, pulse start_ffn_mul
module ffn_silu_ctrl #(
  parameter int             BW_EXP   = 8,
  parameter int             BW_MAN   = 9,
  parameter int             BW_FP    = 17,
  parameter int             VALUE_MK = 128,
  parameter logic [4:0]     MODE_NOP = 5'd0,
  parameter logic [4:0]     MODE_FMA = 5'd1,
  parameter logic [4:0]     MODE_MUL = 5'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  ffn_silu_ctrl_if.slave     bus
);

  localparam int LW = VALUE_MK * BW_FP;
  localparam int MW = VALUE_MK * 5;

  localparam logic [BW_FP-1:0] ONE_W     = {2'b00, {(BW_EXP-1){1'b1}}, {(BW_MAN-1){1'b0}}};
  localparam logic [BW_FP-1:0] HALF_W    = {2'b00, {(BW_EXP-2){1'b1}}, 1'b0, {(BW_MAN-1){1'b0}}};
  localparam logic [BW_FP-1:0] QUARTER_W = {2'b00, {(BW_EXP-3){1'b1}}, 2'b01, {(BW_MAN-1){1'b0}}};

  typedef enum logic [2:0] {
    K0_ISSUE_FMA = 3'd0,
    K1_WAIT      = 3'd1,
    K2_CAP_T     = 3'd2,
    K3_ISSUE_MUL = 3'd3,
    K4_WAIT      = 3'd4,
    K5_CAP_Y     = 3'd5
  } step_e;

  step_e         r_k;
  logic          r_busy;
  logic          r_start_mul;
  logic [LW-1:0] r_x;
  logic [LW-1:0] r_y;
  logic [LW-1:0] r_a;
  logic [LW-1:0] r_b;
  logic [LW-1:0] r_c;
  logic [MW-1:0] r_mode;

  logic [LW-1:0] w_clamp;
  logic [LW-1:0] w_b_fma;
  logic [LW-1:0] w_c_fma;
  logic [MW-1:0] w_mode_fma;
  logic [MW-1:0] w_mode_mul;
  logic [MW-1:0] w_mode_nop;

  // -0 and negatives go to +0; anything above 1.0 saturates to 1.0
  function automatic logic [BW_FP-1:0] clamp_lane(input logic [BW_FP-1:0] w);
    if (w[BW_FP-1])
      return '0;
    else if (w[BW_FP-2:0] > ONE_W[BW_FP-2:0])
      return ONE_W;
    else
      return w;
  endfunction

  always_comb begin
    w_clamp = '0;
    for (int i = 0; i < VALUE_MK; i++)
      w_clamp[i*BW_FP +: BW_FP] = clamp_lane(bus.FMA_out[i*BW_FP +: BW_FP]);
  end

  assign w_b_fma    = {VALUE_MK{QUARTER_W}};
  assign w_c_fma    = {VALUE_MK{HALF_W}};
  assign w_mode_fma = {VALUE_MK{MODE_FMA}};
  assign w_mode_mul = {VALUE_MK{MODE_MUL}};
  assign w_mode_nop = {VALUE_MK{MODE_NOP}};

  // Operand registers default to NOP/zero every cycle; only the two issue
  // steps load them, so they are valid exactly during K0 and K3.
  // The clamped t lives in r_b for the single cycle the MUL needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= K0_ISSUE_FMA;
      r_busy      <= 1'b0;
      r_start_mul <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_mode      <= '0;
    end else begin
      r_start_mul <= 1'b0;
      r_mode      <= w_mode_nop;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      if (!r_busy) begin
        if (bus.start_silu) begin
          r_busy <= 1'b1;
          r_k    <= K0_ISSUE_FMA;
          r_x    <= bus.gate_proj;
          r_mode <= w_mode_fma;
          r_a    <= bus.gate_proj;
          r_b    <= w_b_fma;
          r_c    <= w_c_fma;
        end
      end else begin
        case (r_k)
          K0_ISSUE_FMA: r_k <= K1_WAIT;
          K1_WAIT:      r_k <= K2_CAP_T;
          K2_CAP_T: begin
            r_k    <= K3_ISSUE_MUL;
            r_mode <= w_mode_mul;
            r_a    <= r_x;
            r_b    <= w_clamp;
          end
          K3_ISSUE_MUL: r_k <= K4_WAIT;
          K4_WAIT:      r_k <= K5_CAP_Y;
          K5_CAP_Y: begin
            r_k         <= K0_ISSUE_FMA;
            r_y         <= bus.FMA_out;
            r_busy      <= 1'b0;
            r_start_mul <= 1'b1;
          end
          default: begin
            r_k    <= K0_ISSUE_FMA;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy_silu     = r_busy;
  assign bus.mode_silu     = r_mode;
  assign bus.a_silu        = r_a;
  assign bus.b_silu        = r_b;
  assign bus.c_silu        = r_c;
  assign bus.silu_out      = r_y;
  assign bus.start_ffn_mul = r_start_mul;

endmodule

// File: tb/tb_ffn_silu_ctrl.sv
// Directed bench for ffn_silu_ctrl with a 2-cycle real-valued FMA array model.
module tb_ffn_silu_ctrl;
  localparam int BW_FP    = 17;
  localparam int VALUE_MK = 128;
  localparam int LW       = VALUE_MK * BW_FP;
  localparam int MW       = VALUE_MK * 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ffn_silu_ctrl_if #(.BW_FP(BW_FP), .VALUE_MK(VALUE_MK)) bus ();

  ffn_silu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic real w2r(input logic [16:0] w);
    logic [10:0] e;
    if (w[15:8] == 8'd0) return $bitstoreal({w[16], 63'd0});
    e = {3'b000, w[15:8]} + 11'd896;
    return $bitstoreal({w[16], e, w[7:0], 44'd0});
  endfunction

  function automatic logic [16:0] r2w(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 16'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:44]};
  endfunction

  // FMA array model: operands seen at edge ending cycle k, result visible in cycle k+2
  logic [LW-1:0] fma_s1, fma_s2;
  always @(posedge clk) begin
    logic [4:0] m;
    real ra, rb, rc;
    for (int i = 0; i < VALUE_MK; i++) begin
      m  = bus.mode_silu[i*5 +: 5];
      ra = w2r(bus.a_silu[i*BW_FP +: BW_FP]);
      rb = w2r(bus.b_silu[i*BW_FP +: BW_FP]);
      rc = w2r(bus.c_silu[i*BW_FP +: BW_FP]);
      case (m)
        5'd1:    fma_s1[i*BW_FP +: BW_FP] <= r2w(ra * rb + rc);
        5'd2:    fma_s1[i*BW_FP +: BW_FP] <= r2w(ra * rb);
        default: fma_s1[i*BW_FP +: BW_FP] <= '0;
      endcase
    end
    fma_s2 <= fma_s1;
  end
  assign bus.FMA_out = fma_s2;

  function automatic int lane_of(input logic [LW-1:0] x, input logic [LW-1:0] y);
    for (int i = 0; i < VALUE_MK; i++)
      if (x[i*BW_FP +: BW_FP] !== y[i*BW_FP +: BW_FP]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor results of the most recent run_op
  int            m_busy, m_pulse_at, m_nop_bad, m_y_changes;
  logic [LW-1:0] m_fa, m_fb, m_fc, m_ma, m_mb, m_mc, m_y0;
  logic [MW-1:0] m_fmode, m_mmode;

  task automatic run_op(input int restart_at);
    m_busy = 0; m_pulse_at = -1; m_nop_bad = 0; m_y_changes = 0;
    m_y0 = bus.silu_out;
    m_fa = '1; m_fb = '1; m_fc = '1; m_ma = '1; m_mb = '1; m_mc = '1;
    bus.start_silu = 1'b1;
    tick();
    bus.start_silu = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.busy_silu) m_busy++;
      if (bus.mode_silu == {VALUE_MK{5'd1}}) begin
        m_fa = bus.a_silu; m_fb = bus.b_silu; m_fc = bus.c_silu;
      end else if (bus.mode_silu == {VALUE_MK{5'd2}}) begin
        m_ma = bus.a_silu; m_mb = bus.b_silu; m_mc = bus.c_silu;
      end else if (bus.mode_silu != '0 || bus.a_silu != '0 || bus.b_silu != '0 || bus.c_silu != '0) begin
        m_nop_bad++;
      end
      if (bus.start_ffn_mul) begin
        m_pulse_at = cyc;
        break;
      end
      if (bus.silu_out !== m_y0) m_y_changes++;
      bus.start_silu = (cyc == restart_at);
      tick();
    end
    bus.start_silu = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_silu = 1'b0;
    bus.gate_proj  = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++; if (bus.busy_silu !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_silu); end
    n_tests++; if (bus.start_ffn_mul !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.start_ffn_mul); end
    n_tests++; if (bus.mode_silu !== '0) begin n_fail++; $display("FAIL reset_mode: lane0 got %h want 0", bus.mode_silu[4:0]); end
    n_tests++; if (bus.a_silu !== '0) begin n_fail++; $display("FAIL reset_a: lane0 got %h want 0", bus.a_silu[16:0]); end
    n_tests++; if (bus.b_silu !== '0) begin n_fail++; $display("FAIL reset_b: lane0 got %h want 0", bus.b_silu[16:0]); end
    n_tests++; if (bus.c_silu !== '0) begin n_fail++; $display("FAIL reset_c: lane0 got %h want 0", bus.c_silu[16:0]); end
    n_tests++; if (bus.silu_out !== '0) begin n_fail++; $display("FAIL reset_silu: lane0 got %h want 0", bus.silu_out[16:0]); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_two();
    logic [LW-1:0] exp_v;
    int l;
    bus.gate_proj = {VALUE_MK{17'h08000}};
    run_op(-1);
    exp_v = {VALUE_MK{17'h08000}};
    n_tests++; if (m_fa !== exp_v) begin n_fail++; l = lane_of(m_fa, exp_v); $display("FAIL two_fma_a: lane %0d got %h want %h", l, m_fa[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h07D00}};
    n_tests++; if (m_fb !== exp_v) begin n_fail++; l = lane_of(m_fb, exp_v); $display("FAIL two_fma_b: lane %0d got %h want %h", l, m_fb[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h07E00}};
    n_tests++; if (m_fc !== exp_v) begin n_fail++; l = lane_of(m_fc, exp_v); $display("FAIL two_fma_c: lane %0d got %h want %h", l, m_fc[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h08000}};
    n_tests++; if (m_ma !== exp_v) begin n_fail++; l = lane_of(m_ma, exp_v); $display("FAIL two_mul_a: lane %0d got %h want %h", l, m_ma[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h07F00}};
    n_tests++; if (m_mb !== exp_v) begin n_fail++; l = lane_of(m_mb, exp_v); $display("FAIL two_mul_b_t: lane %0d got %h want %h", l, m_mb[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    n_tests++; if (m_mc !== '0) begin n_fail++; $display("FAIL two_mul_c: lane0 got %h want 0", m_mc[16:0]); end
    exp_v = {VALUE_MK{17'h08000}};
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; l = lane_of(bus.silu_out, exp_v); $display("FAIL two_silu: lane %0d got %h want %h", l, bus.silu_out[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    n_tests++; if (m_pulse_at !== 7) begin n_fail++; $display("FAIL two_pulse_cycle: got %0d want 7", m_pulse_at); end
    n_tests++; if (m_busy !== 6) begin n_fail++; $display("FAIL two_busy_cycles: got %0d want 6", m_busy); end
    n_tests++; if (bus.busy_silu !== 1'b0) begin n_fail++; $display("FAIL two_busy_at_pulse: got %b want 0", bus.busy_silu); end
    n_tests++; if (m_nop_bad !== 0) begin n_fail++; $display("FAIL two_nop_cycles: got %0d bad cycles want 0", m_nop_bad); end
    tick();
    n_tests++; if (bus.start_ffn_mul !== 1'b0) begin n_fail++; $display("FAIL two_pulse_width: got %b want 0", bus.start_ffn_mul); end
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; $display("FAIL two_silu_hold: lane0 got %h want %h", bus.silu_out[16:0], exp_v[16:0]); end
  endtask

  task automatic test_eight();
    logic [LW-1:0] exp_v;
    int l;
    bus.gate_proj = {VALUE_MK{17'h08200}};
    run_op(-1);
    exp_v = {VALUE_MK{17'h07F00}};
    n_tests++; if (m_mb !== exp_v) begin n_fail++; l = lane_of(m_mb, exp_v); $display("FAIL eight_t_clamp: lane %0d got %h want %h", l, m_mb[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h08200}};
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; l = lane_of(bus.silu_out, exp_v); $display("FAIL eight_silu: lane %0d got %h want %h", l, bus.silu_out[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    n_tests++; if (m_pulse_at !== 7) begin n_fail++; $display("FAIL eight_pulse_cycle: got %0d want 7", m_pulse_at); end
    tick();
  endtask

  task automatic test_negative();
    logic [LW-1:0] exp_v;
    int l;
    bus.gate_proj = {VALUE_MK{17'h18100}};
    run_op(-1);
    n_tests++; if (m_mb !== '0) begin n_fail++; l = lane_of(m_mb, '0); $display("FAIL neg_t_clamp: lane %0d got %h want 00000", l, m_mb[l*BW_FP +: BW_FP]); end
    exp_v = {VALUE_MK{17'h10000}};
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; l = lane_of(bus.silu_out, exp_v); $display("FAIL neg_silu: lane %0d got %h want %h", l, bus.silu_out[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    n_tests++; if (m_nop_bad !== 0) begin n_fail++; $display("FAIL neg_nop_cycles: got %0d bad cycles want 0", m_nop_bad); end
    tick();
  endtask

  task automatic test_mixed();
    logic [LW-1:0] g, exp_b, exp_y;
    int l, extra;
    g = '0;
    g[0*BW_FP +: BW_FP] = 17'h08000;
    g[1*BW_FP +: BW_FP] = 17'h18100;
    bus.gate_proj = g;
    exp_b = {VALUE_MK{17'h07E00}};
    exp_b[0*BW_FP +: BW_FP] = 17'h07F00;
    exp_b[1*BW_FP +: BW_FP] = 17'h00000;
    exp_y = '0;
    exp_y[0*BW_FP +: BW_FP] = 17'h08000;
    exp_y[1*BW_FP +: BW_FP] = 17'h10000;
    run_op(3);
    n_tests++; if (m_mb !== exp_b) begin n_fail++; l = lane_of(m_mb, exp_b); $display("FAIL mixed_t: lane %0d got %h want %h", l, m_mb[l*BW_FP +: BW_FP], exp_b[l*BW_FP +: BW_FP]); end
    n_tests++; if (bus.silu_out !== exp_y) begin n_fail++; l = lane_of(bus.silu_out, exp_y); $display("FAIL mixed_silu: lane %0d got %h want %h", l, bus.silu_out[l*BW_FP +: BW_FP], exp_y[l*BW_FP +: BW_FP]); end
    n_tests++; if (m_pulse_at !== 7) begin n_fail++; $display("FAIL mixed_pulse_cycle: got %0d want 7", m_pulse_at); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.start_ffn_mul) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL mixed_extra_pulses: got %0d want 0", extra); end
    n_tests++; if (bus.busy_silu !== 1'b0) begin n_fail++; $display("FAIL mixed_idle: got %b want 0", bus.busy_silu); end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] exp_v;
    int l;
    bus.gate_proj = {VALUE_MK{17'h08000}};
    run_op(-1);
    bus.gate_proj = {VALUE_MK{17'h08200}};
    run_op(-1);
    n_tests++; if (m_y0 !== {VALUE_MK{17'h08000}}) begin n_fail++; $display("FAIL b2b_first: lane0 got %h want 08000", m_y0[16:0]); end
    n_tests++; if (m_y_changes !== 0) begin n_fail++; $display("FAIL b2b_hold: got %0d early changes want 0", m_y_changes); end
    n_tests++; if (m_pulse_at !== 7) begin n_fail++; $display("FAIL b2b_period: got %0d want 7", m_pulse_at); end
    n_tests++; if (m_busy !== 6) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 6", m_busy); end
    exp_v = {VALUE_MK{17'h08200}};
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; l = lane_of(bus.silu_out, exp_v); $display("FAIL b2b_second: lane %0d got %h want %h", l, bus.silu_out[l*BW_FP +: BW_FP], exp_v[l*BW_FP +: BW_FP]); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [LW-1:0] exp_v;
    int pulses;
    bus.gate_proj = {VALUE_MK{17'h18100}};
    bus.start_silu = 1'b1;
    tick();
    bus.start_silu = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (bus.mode_silu !== {VALUE_MK{5'd2}}) begin n_fail++; $display("FAIL abort_at_k3: mode lane0 got %h want 02", bus.mode_silu[4:0]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy_silu !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy_silu); end
    n_tests++; if (bus.mode_silu !== '0) begin n_fail++; $display("FAIL abort_mode: lane0 got %h want 0", bus.mode_silu[4:0]); end
    n_tests++; if (bus.a_silu !== '0 || bus.b_silu !== '0 || bus.c_silu !== '0) begin n_fail++; $display("FAIL abort_abc: lane0 got %h %h %h want 0 0 0", bus.a_silu[16:0], bus.b_silu[16:0], bus.c_silu[16:0]); end
    n_tests++; if (bus.silu_out !== '0) begin n_fail++; $display("FAIL abort_silu: lane0 got %h want 0", bus.silu_out[16:0]); end
    pulses = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.start_ffn_mul) pulses++;
      tick();
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d want 0", pulses); end
    n_tests++; if (bus.busy_silu !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", bus.busy_silu); end
    bus.gate_proj = {VALUE_MK{17'h08000}};
    run_op(-1);
    n_tests++; if (m_pulse_at !== 7) begin n_fail++; $display("FAIL abort_restart_pulse: got %0d want 7", m_pulse_at); end
    exp_v = {VALUE_MK{17'h08000}};
    n_tests++; if (bus.silu_out !== exp_v) begin n_fail++; $display("FAIL abort_restart_silu: lane0 got %h want 08000", bus.silu_out[16:0]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_two();
    test_eight();
    test_negative();
    test_mixed();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ffn_silu_ctrl.md
FFN_SILU_CTRL -- requirements
Module: ffn_silu_ctrl

Interface
REQ-001 SHALL have parameters: BW_EXP=8, exponent width; BW_MAN=9, mantissa width including hidden bit; BW_FP=17, lane word {sign[16], exp[15:8], frac[7:0]}, bias 127; VALUE_MK=128, lane count; MODE_NOP=5'd0; MODE_FMA=5'd1 (a*b+c); MODE_MUL=5'd2 (a*b).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start_silu in 1, one-cycle start pulse; gate_proj in VALUE_MK*BW_FP, gate projection vector x; FMA_out in VALUE_MK*BW_FP, shared FMA array result.
REQ-004 SHALL have ports: busy_silu out 1; mode_silu out VALUE_MK*5, per-lane op; a_silu, b_silu, c_silu out VALUE_MK*BW_FP each, FMA operands; silu_out out VALUE_MK*BW_FP, result buffer feeding the FFN multiply stage as silu_in; start_ffn_mul out 1, one-cycle pulse launching the FFN multiply stage.

Function
REQ-005 SHALL compute per lane the hard-SiLU silu(x) = x * clamp(0.25*x + 0.5, 0, 1) on the shared FMA array; FMA result latency is fixed at 2 cycles (operands driven in cycle k, FMA_out sampled at the rising edge ending cycle k+2).
REQ-006 SHALL sample start_silu only when busy_silu=0, latch gate_proj into x_reg on that edge, set busy_silu=1, and clear step counter k to 0.
REQ-007 SHALL ignore start_silu while busy_silu=1; x_reg, k and all outputs remain unaffected.
REQ-008 SHALL sequence k=0..5 while busy:
- k=0 ISSUE_FMA: mode=MODE_FMA all lanes; a=x_reg; b=17'h07D00 (0.25) broadcast; c=17'h07E00 (0.5) broadcast.
- k=1 WAIT.
- k=2 CAP_T: t_reg <= clamp(FMA_out) at end of cycle.
- k=3 ISSUE_MUL: mode=MODE_MUL; a=x_reg; b=t_reg; c=0.
- k=4 WAIT.
- k=5 CAP_Y: silu_out <= FMA_out at end of cycle; busy_silu <= 0; k <= 0.
REQ-009 SHALL clamp per lane on the 17-bit word:
- sign=1: result 17'h00000 (negative values and -0 go to +0).
- sign=0 and word[15:0] > 16'h7F00: result 17'h07F00 (1.0).
- otherwise: pass unchanged.
REQ-010 SHALL drive mode_silu=MODE_NOP and a/b/c=0 in every cycle other than k=0 and k=3 of a busy operation, including while idle.
REQ-011 SHALL pulse start_ffn_mul high for exactly one cycle, in the cycle immediately after k=5, coincident with the first cycle of busy_silu=0; silu_out is already valid in that cycle.
REQ-012 SHALL hold silu_out stable from the k=5 capture until the next k=5 capture; a new start SHALL NOT disturb silu_out before its own k=5 capture.
REQ-013 SHALL accept a start_silu arriving in the start_ffn_mul pulse cycle, giving back-to-back operations with a 7-cycle start-to-start period.
REQ-014 busy_silu SHALL be high for exactly 6 cycles per operation.

Reset
REQ-015 rst_n=0 SHALL asynchronously clear busy_silu, k, x_reg, t_reg, silu_out, start_ffn_mul, mode/a/b/c outputs to 0.
REQ-016 SHALL abort any in-flight operation on reset; no start_ffn_mul pulse is produced for the aborted operation, and the block returns idle after release.

Verification
REQ-017 Bench SHALL model FMA_out as a per-lane a*b+c / a*b result with 2-cycle latency, and SHALL cover these scenarios:
- x=2.0 (17'h08000) all lanes -> FMA issue a=17'h08000, b=17'h07D00, c=17'h07E00; t=1.0 (17'h07F00) unclamped; silu_out=17'h08000; start_ffn_mul 7 cycles after start.
- x=8.0 (17'h08200) -> FMA yields 2.5; b at MUL issue =17'h07F00; silu_out=8.0.
- x=-4.0 (17'h18100) -> FMA yields -0.5; t clamped to 17'h00000; silu_out = model of -4.0*0 (signed zero).
- Mixed lanes (lane0 2.0, lane1 -4.0, lane2 0.0) -> per-lane independent results; second start_silu pulsed at k=2 ignored, exactly one start_ffn_mul pulse.
- Back-to-back start in the start_ffn_mul cycle -> second result captured 7 cycles later; silu_out holds the first result until then.
- rst_n asserted at k=3 -> all outputs 0 immediately; no start_ffn_mul pulse; a fresh start after release completes normally.
